// File: rtl/chunk_serial_adder.sv
// chunk_serial_adder: multi-cycle add/subtract, CHUNK bits per cycle through a registered carry.
module chunk_serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = $clog2(NCHUNK + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, r_q, r_d;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic [CHUNK:0]   cs;
  logic             cmsb, last;
  always_comb begin
    cs   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_q};
    cmsb = cs[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
    // each chunk enters at the top so the result is aligned after NCHUNK shifts
    r_d  = (r_q >> CHUNK) | (WIDTH'(cs[CHUNK-1:0]) << (WIDTH - CHUNK));
    last = cnt_q == CW'(NCHUNK - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      sum_o   <= '0;
      cout_o  <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          a_q     <= a_i;
          b_q     <= sub_i ? ~b_i : b_i;
          c_q     <= sub_i | cin_i;
          cnt_q   <= '0;
          busy_o  <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          a_q   <= a_q >> CHUNK;
          b_q   <= b_q >> CHUNK;
          c_q   <= cs[CHUNK];
          r_q   <= r_d;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            sum_o   <= r_d;
            cout_o  <= cs[CHUNK];
            ovf_o   <= cmsb ^ cs[CHUNK];
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
